// File: rtl/nibble_serializer.sv
// Serializes WORD_WIDTH-bit words into NIBBLE_WIDTH-bit chunks over valid/ready handshakes.
// One active word plus one pending word allow back-to-back words to stream with no bubbles.
module nibble_serializer #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned NIBBLE_WIDTH = 4,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_clear,
  input  logic [WORD_WIDTH-1:0]                      i_in_word,
  input  logic                                       i_in_valid,
  output logic                                       o_in_ready,
  output logic [NIBBLE_WIDTH-1:0]                    o_out_nibble,
  output logic                                       o_out_valid,
  input  logic                                       i_out_ready,
  output logic [$clog2(WORD_WIDTH/NIBBLE_WIDTH)-1:0] o_out_index,
  output logic                                       o_out_last,
  output logic                                       o_busy
);

  localparam int unsigned NIBBLES = WORD_WIDTH / NIBBLE_WIDTH;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);
  localparam int unsigned BIT_W   = $clog2(WORD_WIDTH);

  if ((WORD_WIDTH % NIBBLE_WIDTH) != 0 || NIBBLES < 2) begin : g_param_check
    $error("nibble_serializer: WORD_WIDTH must be a multiple of NIBBLE_WIDTH with at least 2 chunks");
  end

  logic [WORD_WIDTH-1:0] r_act_word;
  logic                  r_act_valid;
  logic [IDX_W-1:0]      r_cnt;
  logic [WORD_WIDTH-1:0] r_pend_word;
  logic                  r_pend_valid;

  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_done;
  logic [IDX_W-1:0]      w_index;
  logic [BIT_W-1:0]      w_base;

  // Output decode: everything except in_ready depends on registers only
  assign w_last       = r_act_valid && (r_cnt == IDX_W'(NIBBLES - 1));
  assign w_index      = MSB_FIRST ? (IDX_W'(NIBBLES - 1) - r_cnt) : r_cnt;
  assign w_base       = BIT_W'(w_index) * BIT_W'(NIBBLE_WIDTH);

  assign o_out_valid  = r_act_valid;
  assign o_out_last   = w_last;
  assign o_out_index  = r_act_valid ? w_index : '0;
  assign o_out_nibble = r_act_valid ? r_act_word[w_base +: NIBBLE_WIDTH] : '0;
  assign o_in_ready   = !r_pend_valid && !i_clear;
  assign o_busy       = r_act_valid || r_pend_valid;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_xfer       = r_act_valid && i_out_ready;
  assign w_done       = w_xfer && w_last;

  // Active/pending word bookkeeping; a finishing word hands over to pending first, then to a new accept
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_act_word   <= '0;
      r_act_valid  <= 1'b0;
      r_cnt        <= '0;
      r_pend_word  <= '0;
      r_pend_valid <= 1'b0;
    end else if (i_clear) begin
      r_act_valid  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
    end else if (w_done) begin
      r_cnt <= '0;
      if (r_pend_valid) begin
        r_act_word   <= r_pend_word;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_act_word <= i_in_word;
      end else begin
        r_act_valid <= 1'b0;
      end
    end else begin
      if (w_xfer) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
      if (w_accept) begin
        if (!r_act_valid) begin
          r_act_word  <= i_in_word;
          r_act_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_pend_word  <= i_in_word;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared each cycle against a word-queue reference model.
module tb_nibble_serializer;

  localparam int unsigned WW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned N  = WW / NW;
  localparam int unsigned IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic [WW-1:0] in_word = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic          rdy0, val0, last0, busy0;
  logic [NW-1:0] nib0;
  logic [IW-1:0] idx0;
  logic          rdy1, val1, last1, busy1;
  logic [NW-1:0] nib1;
  logic [IW-1:0] idx1;

  always #5 clk = ~clk;

  nibble_serializer #(.WORD_WIDTH(WW), .NIBBLE_WIDTH(NW), .MSB_FIRST(1'b0)) u_lsb (
    .i_clock(clk), .i_reset(rst), .i_clear(clr), .i_in_word(in_word), .i_in_valid(in_valid),
    .o_in_ready(rdy0), .o_out_nibble(nib0), .o_out_valid(val0), .i_out_ready(out_ready),
    .o_out_index(idx0), .o_out_last(last0), .o_busy(busy0)
  );

  nibble_serializer #(.WORD_WIDTH(WW), .NIBBLE_WIDTH(NW), .MSB_FIRST(1'b1)) u_msb (
    .i_clock(clk), .i_reset(rst), .i_clear(clr), .i_in_word(in_word), .i_in_valid(in_valid),
    .o_in_ready(rdy1), .o_out_nibble(nib1), .o_out_valid(val1), .i_out_ready(out_ready),
    .o_out_index(idx1), .o_out_last(last1), .o_busy(busy1)
  );

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [WW-1:0] q[$];          // words held by the block, oldest first
  int unsigned   pos = 0;       // chunks already delivered from q[0]
  bit            last_accept = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] chunk(input logic [WW-1:0] w, input int unsigned k);
    logic [WW-1:0] s;
    s = w >> (k * NW);
    return s[NW-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    pos = 0;
  endtask

  // One clock: compare at negedge, advance the model, return just after the rising edge
  task automatic cycle();
    bit            exp_ready, exp_valid, acc, xf;
    int unsigned   k0, k1;
    @(negedge clk);
    exp_ready = (q.size() < 2) && !clr;
    exp_valid = (q.size() > 0);
    check("lsb_in_ready", 32'(rdy0), 32'(exp_ready));
    check("msb_in_ready", 32'(rdy1), 32'(exp_ready));
    check("lsb_out_valid", 32'(val0), 32'(exp_valid));
    check("msb_out_valid", 32'(val1), 32'(exp_valid));
    check("lsb_busy", 32'(busy0), 32'(exp_valid));
    check("msb_busy", 32'(busy1), 32'(exp_valid));
    if (exp_valid) begin
      k0 = pos;
      k1 = N - 1 - pos;
      check("lsb_nibble", 32'(nib0), 32'(chunk(q[0], k0)));
      check("msb_nibble", 32'(nib1), 32'(chunk(q[0], k1)));
      check("lsb_index", 32'(idx0), k0);
      check("msb_index", 32'(idx1), k1);
      check("lsb_last", 32'(last0), 32'(pos == N - 1));
      check("msb_last", 32'(last1), 32'(pos == N - 1));
    end else begin
      check("lsb_idle_last", 32'(last0), 32'd0);
    end
    acc = in_valid && exp_ready;
    xf  = exp_valid && out_ready;
    last_accept = acc;
    if (clr) begin
      model_reset();
    end else begin
      if (xf) begin
        if (pos == N - 1) begin
          void'(q.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (acc) q.push_back(in_word);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] w);
    in_valid = 1'b1;
    in_word  = w;
    last_accept = 1'b0;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (last_accept) break;
    end
    if (!last_accept) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(val0 | val1), 32'd0);
    check({tag, "_busy"}, 32'(busy0 | busy1), 32'd0);
    check({tag, "_ready"}, 32'(rdy0 & rdy1), 32'd1);
    check({tag, "_nibble"}, 32'(nib0 | nib1), 32'd0);
    check({tag, "_index"}, 32'(idx0 | idx1), 32'd0);
    check({tag, "_last"}, 32'(last0 | last1), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Single word, both chunk orders
    out_ready = 1'b1;
    send(32'h8765_4321);
    repeat (10) cycle();

    // Back-to-back streaming keeps pending full
    send(32'hA5A5_A5A5);
    send(32'h0F0F_0F0F);
    repeat (20) cycle();

    // Backpressure on cycles 2-4 after acceptance
    send(32'h1234_5678);
    for (int k = 1; k <= 12; k++) begin
      out_ready = !(k >= 2 && k <= 4);
      cycle();
    end
    out_ready = 1'b1;

    // Clear mid-word with a pending word held
    send(32'h1111_1111);
    send(32'h2222_2222);
    repeat (2) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
    send(32'hDEAD_BEEF);
    repeat (10) cycle();

    // Async reset between clock edges while the fifth chunk is presented
    send(32'h1357_9BDF);
    repeat (4) cycle();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    send(32'hCAFE_F00D);
    repeat (10) cycle();

    // Randomized traffic with occasional clears
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
- Upstream stage of the nibble-select mux.
- Accepts 32-bit words over a valid/ready handshake and emits them as a stream of 4-bit nibbles, one per handshake.
- Generates the nibble index that drives the mux select, so the downstream narrow output path carries one nibble per cycle.
- Holds one active word plus one pending word, so back-to-back words stream with no bubble cycles.

Parameters:
WORD_WIDTH, 32, width of input word.
NIBBLE_WIDTH, 4, width of each output chunk.
MSB_FIRST, 0, 0 = nibble 0 (bits [3:0]) sent first; 1 = most-significant nibble sent first.
NIBBLES (localparam), WORD_WIDTH/NIBBLE_WIDTH, chunks per word (8 at defaults).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; drops all held data.
in_word  input  WORD_WIDTH  word to serialize.
in_valid  input  1  in_word is valid.
in_ready  output  1  block can accept a word this cycle.
out_nibble  output  NIBBLE_WIDTH  current chunk.
out_valid  output  1  out_nibble is valid.
out_ready  input  1  consumer takes out_nibble this cycle.
out_index  output  $clog2(NIBBLES)  physical chunk position within the word (mux select).
out_last  output  1  current chunk is the final one of its word.
busy  output  1  active or pending word held.

Behaviour:
- Elaboration check: WORD_WIDTH % NIBBLE_WIDTH == 0 and NIBBLES >= 2. Otherwise $error.
- State registers:
  - act_word, act_valid, cnt (0..NIBBLES-1).
  - pend_word, pend_valid.
- Reset (async), all registers cleared:
  - out_valid=0, out_nibble=0, out_index=0, out_last=0, busy=0, in_ready=1.
- Outputs are decoded from registers only. No combinational path from in_* or out_ready to any output.
  - out_valid = act_valid.
  - out_index = MSB_FIRST ? NIBBLES-1-cnt : cnt.
  - out_nibble = act_word[out_index*NIBBLE_WIDTH +: NIBBLE_WIDTH].
  - out_last = act_valid && cnt == NIBBLES-1.
  - in_ready = !pend_valid && !clear.
  - busy = act_valid | pend_valid.
- Events:
  - accept = in_valid && in_ready.
  - xfer = out_valid && out_ready.
  - done = xfer && out_last.
- Stall: while out_valid && !out_ready, out_nibble, out_index and out_last stay stable.
- Per cycle (clear=0):
  - xfer && !out_last: cnt <= cnt+1.
  - done: cnt <= 0, then the first matching rule applies:
    - pend_valid: act_word <= pend_word, pend_valid <= 0.
    - else accept: act_word <= in_word, accept bypasses pending.
    - else act_valid <= 0.
  - accept && !done:
    - act_valid == 0: load act_word, act_valid <= 1, cnt <= 0.
    - else: load pend_word, pend_valid <= 1.
  - done && pend_valid: in_ready was 0, so no accept is possible that cycle.
- Latency: a word accepted into an empty block shows out_valid on the next cycle (1 cycle). Its first nibble is presented then.
- Throughput: with out_ready held at 1, one nibble per cycle, NIBBLES cycles per word, zero bubbles between consecutive words if the producer keeps pending filled.
- Clear: highest priority after reset.
  - act_valid, pend_valid and cnt are zeroed on that edge. Word registers need not be zeroed.
  - in_ready is 0 during the clear cycle. Any xfer that cycle is ignored internally.
- Reset mid-word: immediate return to reset values. No partial word resumes.
- cnt wrap: returns to 0 only via done or clear. Never free-runs.

Test Plan:
- Single word, LSB-first: reset, in_word=0x87654321 accepted at cycle 0, out_ready=1 -> out_valid from cycle 1. out_nibble 1,2,3,4,5,6,7,8 on cycles 1-8, out_index 0..7, out_last only on cycle 8. Cycle 9: out_valid=0, busy=0.
- Back-to-back streaming: producer offers 0xA5A5A5A5 then 0x0F0F0F0F with in_valid held, out_ready=1 -> 16 consecutive valid nibbles with no gap. in_ready=0 while pending full, reasserting the cycle after the first word's last nibble.
- Backpressure: out_ready low on cycles 2-4 during word 0x12345678 -> out_nibble=0x7, out_index=1 held stable through the stall. Full sequence 8,7,6,...,1 is delivered intact with no loss or duplication.
- MSB_FIRST=1: word 0x87654321 -> nibbles 8,7,6,5,4,3,2,1, out_index 7..0, out_last with nibble 1.
- Clear mid-word: clear pulsed after 3 nibbles with a pending word held -> next cycle out_valid=0, busy=0, in_ready=1. A new word 0xDEADBEEF then serializes from nibble 0xF.
- Async reset mid-word: reset asserted between clock edges during nibble 5 -> outputs reach reset values without a clock edge. After release, the block is idle and accepts a word normally.
